// File: rtl/encoder_dense_seq_if.sv
// Purpose : valid/ready bundle for encoder_dense_seq: x/w/b request stream in, out/ovf result stream back.
// Ports   : in_valid/in_ready + x, w, b (request); out_valid/out_ready + out, ovf (result).
// Modports: master = producer/consumer side (testbench or upstream), slave = the dense layer.
interface encoder_dense_seq_if #(
  parameter int N_INPUT  = 9,
  parameter int M_OUTPUT = 4,
  parameter int BITSIZE  = 32
);
  logic                                in_valid;
  logic                                in_ready;
  logic [N_INPUT*BITSIZE-1:0]          x;
  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] w;
  logic [M_OUTPUT*BITSIZE-1:0]         b;
  logic                                out_valid;
  logic                                out_ready;
  logic [M_OUTPUT*BITSIZE-1:0]         out;
  logic [M_OUTPUT-1:0]                 ovf;

  modport master (
    output in_valid, x, w, b, out_ready,
    input  in_ready, out_valid, out, ovf
  );

  modport slave (
    input  in_valid, x, w, b, out_ready,
    output in_ready, out_valid, out, ovf
  );
endinterface

// File: rtl/encoder_dense_seq.sv
// Purpose : fixed-point dense layer out[j] = sat(sum_i x[i]*w[j][i] + b[j]); serial over inputs, one MAC lane per output.
// Latency : accept at edge T0 -> out_valid after edge T0+N_INPUT+1; initiation interval N_INPUT+3 with out_ready high.
// Backpr. : result held in HOLD until out_ready; in_ready is high only in IDLE, so upstream stalls meanwhile.
// Ports   : clk, rst_n (synchronous, active low), bus (encoder_dense_seq_if.slave).
// Option  : define ENCODER_RELU_EN to clamp negative saturated results to zero (ovf still reports saturation).
module encoder_dense_seq #(
  parameter int N_INPUT  = 9,
  parameter int M_OUTPUT = 4,
  parameter int BITSIZE  = 32,
  parameter int FRAC     = 16,
  parameter int GUARD    = 8
) (
  input logic               clk,
  input logic               rst_n,
  encoder_dense_seq_if.slave bus
);
  localparam int ACCW = BITSIZE + GUARD;
  localparam int PW   = 2 * BITSIZE;
  // Working width for clamping: wide enough for a shifted product and for the sum of two accumulator values.
  localparam int WW   = ((PW > ACCW) ? PW : ACCW) + 1;
  localparam int SW   = ACCW + 1;
  localparam int KW   = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;

  localparam logic signed [WW-1:0] ACC_MAX = {{(WW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
  localparam logic signed [WW-1:0] ACC_MIN = {{(WW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};
  localparam logic signed [SW-1:0] OUT_MAX = {{(SW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [SW-1:0] OUT_MIN = {{(SW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, BIAS, HOLD} state_t;
  state_t state, state_nxt;

  logic [KW-1:0]                       k;
  logic                                last_k;
  logic [N_INPUT*BITSIZE-1:0]          x_r;
  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] w_r;
  logic [M_OUTPUT*BITSIZE-1:0]         b_r;
  logic signed [ACCW-1:0]              acc   [M_OUTPUT];
  logic signed [ACCW-1:0]              mac_l [M_OUTPUT];
  logic [BITSIZE-1:0]                  res_l [M_OUTPUT];
  logic                                ovf_l [M_OUTPUT];
  logic [M_OUTPUT*BITSIZE-1:0]         out_q;
  logic [M_OUTPUT-1:0]                 ovf_q;

  assign last_k = (k == KW'(N_INPUT - 1));

  for (genvar j = 0; j < M_OUTPUT; j++) begin : g_lane
    logic signed [BITSIZE-1:0] xk, wk, bj;
    logic signed [PW-1:0]      xe, we, prod, prod_sh;
    logic signed [WW-1:0]      term, term_c, acc_ext, sum;
    logic signed [SW-1:0]      biased;
    logic [BITSIZE-1:0]        sat_val;
    logic                      sat_hi, sat_lo;

    assign xk = x_r[k*BITSIZE +: BITSIZE];
    assign wk = w_r[(j*N_INPUT + k)*BITSIZE +: BITSIZE];
    assign bj = b_r[j*BITSIZE +: BITSIZE];

    assign xe      = {{BITSIZE{xk[BITSIZE-1]}}, xk};
    assign we      = {{BITSIZE{wk[BITSIZE-1]}}, wk};
    assign prod    = xe * we;
    assign prod_sh = prod >>> FRAC;
    assign term    = {{(WW-PW){prod_sh[PW-1]}}, prod_sh};

    // A single product can already exceed the accumulator (e.g. two near-full-scale words), and the
    // running sum can leave it too; both are clamped so a large result saturates instead of wrapping.
    assign term_c  = (term > ACC_MAX) ? ACC_MAX : ((term < ACC_MIN) ? ACC_MIN : term);
    assign acc_ext = {{(WW-ACCW){acc[j][ACCW-1]}}, acc[j]};
    assign sum     = term_c + acc_ext;
    assign mac_l[j] = (sum > ACC_MAX) ? ACC_MAX[ACCW-1:0] :
                      ((sum < ACC_MIN) ? ACC_MIN[ACCW-1:0] : sum[ACCW-1:0]);

    assign biased  = {acc[j][ACCW-1], acc[j]} + {{(SW-BITSIZE){bj[BITSIZE-1]}}, bj};
    assign sat_hi  = (biased > OUT_MAX);
    assign sat_lo  = (biased < OUT_MIN);
    assign sat_val = sat_hi ? {1'b0, {(BITSIZE-1){1'b1}}} :
                     (sat_lo ? {1'b1, {(BITSIZE-1){1'b0}}} : biased[BITSIZE-1:0]);
`ifdef ENCODER_RELU_EN
    assign res_l[j] = sat_val[BITSIZE-1] ? '0 : sat_val;
`else
    assign res_l[j] = sat_val;
`endif
    assign ovf_l[j] = sat_hi | sat_lo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = MAC;
      MAC:     if (last_k)        state_nxt = BIAS;
      BIAS:                       state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k     <= '0;
      out_q <= '0;
      ovf_q <= '0;
      for (int j = 0; j < M_OUTPUT; j++) acc[j] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          x_r <= bus.x;
          w_r <= bus.w;
          b_r <= bus.b;
          k   <= '0;
          for (int j = 0; j < M_OUTPUT; j++) acc[j] <= '0;
        end
        MAC: begin
          k <= k + 1'b1;
          for (int j = 0; j < M_OUTPUT; j++) acc[j] <= mac_l[j];
        end
        BIAS: begin
          for (int j = 0; j < M_OUTPUT; j++) begin
            out_q[j*BITSIZE +: BITSIZE] <= res_l[j];
            ovf_q[j]                    <= ovf_l[j];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: doc/encoder_dense_seq.md
# encoder_dense_seq

Parametrised, handshake-driven fixed-point dense layer that computes out[j] = sat(sum_i x[i]*w[j][i] + b[j]) for any input and output count. It serialises over inputs and keeps one multiply-accumulate lane per output. It replaces the fixed 9-input/4-output pipelined encoder in the Level-1 encoder path and feeds the next layer through a valid/ready stream. Accumulation uses widened sums with saturation, so the result does not wrap on overflow.

## Interface
- N_INPUT, 9, input vector length (>=1)
- M_OUTPUT, 4, output vector length (>=1)
- BITSIZE, 32, two's-complement word width of x, w, b, out
- FRAC, 16, fraction bits of the shared Q format (0 <= FRAC < BITSIZE)
- GUARD, 8, extra accumulator MSBs; accumulator width is BITSIZE+GUARD
- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  x/w/b bundle valid
- in_ready  out  1  block can accept a bundle
- x  in  N_INPUT*BITSIZE  element i at [i*BITSIZE +: BITSIZE]
- w  in  N_INPUT*M_OUTPUT*BITSIZE  w[j][i] at [(j*N_INPUT+i)*BITSIZE +: BITSIZE]
- b  in  M_OUTPUT*BITSIZE  b[j] at [j*BITSIZE +: BITSIZE]
- out_valid  out  1  out holds a result
- out_ready  in  1  consumer accepts out
- out  out  M_OUTPUT*BITSIZE  out[j] at [j*BITSIZE +: BITSIZE]
- ovf  out  M_OUTPUT  per-lane flag, set when that lane saturated

## Operation
- The FSM has four states: IDLE, MAC, BIAS and HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid, register x, w and b, clear all accumulators and the index counter k, then go to MAC.
- MAC:
  - Each cycle, every lane j adds (x[k]*w[j][k]) >>> FRAC to acc[j].
  - The product is 2*BITSIZE wide and signed. The shift is arithmetic, which truncates toward -inf. The shifted product is sign-extended to BITSIZE+GUARD.
  - k increments. After the term with k=N_INPUT-1, go to BIAS.
- BIAS:
  - Compute acc[j]+sext(b[j]), then clamp it to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
  - Register the clamped value into out[j]. Set ovf[j] if clamping occurred.
  - Then go to HOLD.
- HOLD:
  - out_valid=1. out and ovf are stable until the handshake.
  - When out_ready=1, go to IDLE on the next edge.
- Intermediate accumulator overflow inside the guard bits is not detected. GUARD must be at least ceil(log2(N_INPUT))+1.
- in_ready is 1 only in IDLE. in_valid in other states is ignored, and the bundle is not captured.
- Inputs are captured once, so x, w and b may change freely after acceptance.

## Timing
- Reset (rst_n=0 at an edge) has these effects:
  - State goes to IDLE; k=0 and all accumulators are cleared.
  - Resulting outputs: out=0, ovf=0, out_valid=0, in_ready=1 after that edge.
  - Reset wins over every other event, including mid-MAC and mid-HOLD. Partial results are discarded.
- Latency: an accept at edge T0 gives out_valid=1 after edge T0+N_INPUT+1.
- Minimum initiation interval is N_INPUT+3 cycles, with out_ready tied high.
- With N_INPUT=1, MAC lasts exactly one cycle.
- If out_ready is held low, HOLD persists indefinitely and in_ready stays 0.
- When out_valid and out_ready are both high at edge T, in_ready=1 after T. The earliest next accept is at edge T+1.

## Configuration
- ENCODER_RELU_EN defined: BIAS applies ReLU after saturation. Negative results become 0 and ovf still reflects saturation.
- ENCODER_RELU_EN undefined: signed saturated results are passed through unchanged.

## Test plan
- Basic case: FRAC=16, N=9, M=4, all x=1.0 (0x00010000), w[j][i]=0.5, b[j]=j*1.0 -> out=4.5, 5.5, 6.5, 7.5; out_valid after edge T0+10; ovf=0.
- Signed case: x=-2.0, w=0.25 for all i, b=0 -> out=-4.5 (0xFFFB8000) without ENCODER_RELU_EN, 0 with it.
- Saturation: N=9, all x=w=0x7FFF0000 -> out=0x7FFFFFFF, ovf=all ones. Negating w -> out=0x80000000.
- Backpressure: hold out_ready=0 for 20 cycles -> out stable, in_ready=0, a second in_valid is ignored; release -> in_ready=1 the next cycle and the second bundle is accepted.
- Reset mid-operation: rst_n=0 during MAC at k=4 -> out_valid=0, out=0, in_ready=1 after that edge; a fresh bundle then yields the correct result.
- Parameter sweep: N=1, M=1, BITSIZE=16, FRAC=8, x=1.5, w=2.0, b=-1.0 -> out=2.0 (0x0200) after edge T0+2.
